// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid stage: occupancy state encoding and default payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_t;

    localparam int PIPE_DATA_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping. Cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
//
// state    | meaning
// ST_EMPTY | no entry held, in_ready=1, out_valid=0
// ST_HALF  | main holds the output entry, in_ready=1
// ST_FULL  | main + skid hold entries, in_ready=0
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W_DEFAULT,
    parameter int CLEAR_ON_FLUSH = 0,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    pipe_state_t       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              accept;
    logic              emit;

    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Handshake outputs are registered next to the state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state       <= ST_HALF;
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HALF: begin
                    if (accept && emit) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        state      <= ST_FULL;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (emit) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state      <= ST_HALF;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomised bench for pipe_skid_stage against a 2-deep FIFO occupancy model.
module tb_pipe_skid_stage;

    localparam int DATA_W = 32;
`ifdef PIPE_STALL_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    pipe_skid_stage #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (0),
        .CNT_W          (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] model_q[$];
    int stall_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vs_model();
        check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        if (model_q.size() > 0) check("out_data", 64'(out_data), 64'(model_q[0]));
`ifdef PIPE_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
    endtask

    // One clock: called just after a negedge; checks, drives, advances the model at the posedge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
        bit full_before;
        check_vs_model();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush_i   = f;
        @(posedge clk);
        full_before = (model_q.size() == 2);
        if (model_q.size() > 0 && !r && stall_m < STALL_MAX) stall_m++;
        if (f) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && r) void'(model_q.pop_front());
            if (!full_before && v) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
`ifdef PIPE_STALL_CNT_EN
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_q.delete();
        stall_m = 0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // Reset while FULL: outputs must clear asynchronously.
        step(1'b1, 32'h1111_0001, 1'b0, 1'b0);
        step(1'b1, 32'h1111_0002, 1'b0, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        stall_m = 0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 1..100 with out_ready high.
        for (int i = 1; i <= 100; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B then drain.
        step(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_data", 64'(out_data), 64'hAAAA_AAAA);
        step(1'b1, 32'hCCCC_CCCC, 1'b1, 1'b0);
        check("bp_second", 64'(out_data), 64'hBBBB_BBBB);
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_drained", 64'(out_valid), 64'd0);

        // Flush while FULL with a same-cycle input.
        step(1'b1, 32'h0D0D_0001, 1'b0, 1'b0);
        step(1'b1, 32'h0D0D_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0D0D_0003, 1'b1, 1'b1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 32'h0E0E_0001, 1'b1, 1'b0);
        check("post_flush_data", 64'(out_data), 64'h0E0E_0001);
        step(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(99) < 70), DATA_W'($urandom), ($urandom_range(99) < 60),
                 ($urandom_range(63) == 0));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STALL_CNT_EN
        apply_reset();
        step(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", 64'(stall_cnt), 64'd15);
        step(1'b0, '0, 1'b0, 1'b1);
        check("stall_after_flush", 64'(stall_cnt), 64'd15);
        check("stall_flush_valid", 64'(out_valid), 64'd0);
`endif

        check_vs_model();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
